// File: rtl/proc_issue_arbiter_if.sv
// Bundle of the requester, core and response signals around the issue arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system.
interface proc_issue_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 10
);
    localparam int ID_W = $clog2(NUM_REQ);

    // requester side
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_instr;
    logic [NUM_REQ-1:0]            req_ready;

    // core side
    logic [DATA_WIDTH-1:0]         core_instr;
    logic                          core_start;
    logic                          core_done;
    logic [DATA_WIDTH-1:0]         core_result;

    // response side
    logic                          rsp_valid;
    logic [ID_W-1:0]               rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_err;
    logic                          rsp_ready;
    logic [ADDR_W-1:0]             wb_addr;
    logic                          busy;

    modport master (
        input  req_valid, req_instr, core_done, core_result, rsp_ready,
        output req_ready, core_instr, core_start,
        output rsp_valid, rsp_id, rsp_data, rsp_err, wb_addr, busy
    );

    modport slave (
        output req_valid, req_instr, core_done, core_result, rsp_ready,
        input  req_ready, core_instr, core_start,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, wb_addr, busy
    );
endinterface

// File: rtl/proc_issue_arbiter.sv
// Round-robin issue arbiter: shares one pipelined core between NUM_REQ requesters,
// one transaction at a time, with a core timeout and a wrapping result-memory address.
module proc_issue_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 10,
    parameter int TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    proc_issue_arbiter_if.master bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic [ID_W-1:0]       r_rr;
    logic [ID_W-1:0]       r_id;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_valid;
    logic                  r_rsp_err;
    logic                  r_core_start;
    logic                  r_busy;
    logic [ADDR_W-1:0]     r_wb_addr;
    logic [CNT_W-1:0]      r_cnt;

    logic [2*NUM_REQ-1:0]  w_valid_dbl;
    logic [2*NUM_REQ-1:0]  w_valid_shr;
    logic [NUM_REQ-1:0]    w_valid_rot;
    logic [ID_W:0]         w_rr_plus1;
    logic [ID_W:0]         w_sum;
    logic [ID_W-1:0]       w_off;
    logic [ID_W-1:0]       w_grant_id;
    logic [NUM_REQ-1:0]    w_grant_onehot;
    logic [DATA_WIDTH-1:0] w_lane [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_grant_instr;
    logic                  w_any;
    logic                  w_accept;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_timeout;
    logic                  w_rsp_hs;

    // Rotate the request vector so bit 0 is the requester just after the last winner;
    // doubling the vector makes the wrap-around free.
    assign w_valid_dbl = {bus.req_valid, bus.req_valid};
    assign w_rr_plus1  = {1'b0, r_rr} + (ID_W+1)'(1);
    assign w_valid_shr = w_valid_dbl >> w_rr_plus1;
    assign w_valid_rot = w_valid_shr[NUM_REQ-1:0];
    assign w_any       = |bus.req_valid;

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_valid_rot[k]) begin
                w_off = ID_W'(k);
            end
        end
    end

    // Offset back to an absolute index; the sum never reaches 2*NUM_REQ, so one subtract wraps it.
    assign w_sum      = w_rr_plus1 + {1'b0, w_off};
    assign w_grant_id = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ))
                                                      : w_sum[ID_W-1:0];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign w_lane[gi]         = bus.req_instr[gi*DATA_WIDTH +: DATA_WIDTH];
        assign w_grant_onehot[gi] = (w_grant_id == ID_W'(gi));
    end

    assign w_grant_instr = w_lane[w_grant_id];
    assign w_accept      = (r_state == S_IDLE) && w_any;
    assign bus.req_ready = w_accept ? w_grant_onehot : '0;

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT));
    assign w_rsp_hs  = r_rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr         <= ID_W'(NUM_REQ - 1);
            r_id         <= '0;
            r_instr      <= '0;
            r_rsp_data   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
            r_wb_addr    <= '0;
            r_cnt        <= '0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_instr      <= w_grant_instr;
                        r_id         <= w_grant_id;
                        r_rr         <= w_grant_id;
                        r_core_start <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    // A completion in the timeout cycle still counts as a good result.
                    if (bus.core_done) begin
                        r_rsp_data  <= bus.core_result;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_timeout) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_wb_addr   <= r_wb_addr + ADDR_W'(1);
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.core_instr = r_instr;
    assign bus.core_start = r_core_start;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.wb_addr    = r_wb_addr;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_proc_issue_arbiter.sv
// Randomized bench for proc_issue_arbiter: the bench plays requesters, core and response
// consumer, and predicts each transaction from a round-robin/timeout model.
module tb_proc_issue_arbiter;
    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int AW  = 10;
    localparam int AW2 = 2;
    localparam int TO  = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    proc_issue_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ADDR_W(AW))  bus ();
    proc_issue_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ADDR_W(AW2)) bus2 ();

    // the narrow-address instance sees identical stimulus
    assign bus2.req_valid   = bus.req_valid;
    assign bus2.req_instr   = bus.req_instr;
    assign bus2.core_done   = bus.core_done;
    assign bus2.core_result = bus.core_result;
    assign bus2.rsp_ready   = bus.rsp_ready;

    proc_issue_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    proc_issue_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ADDR_W(AW2), .TIMEOUT(TO)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int model_last = NR - 1;
    int model_wb   = 0;
    int txn_no     = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s txn=%0d got=%0h exp=%0h t=%0t", tag, txn_no, got, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [NR-1:0] m);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (model_last + k) % NR;
            if (m[i]) return i;
        end
        return 0;
    endfunction

    // Entered and left at posedge+1; the request is presented in this cycle.
    task automatic run_txn(input logic [NR-1:0] mask, input logic [DW-1:0] instr_g,
                           input int delay, input logic [DW-1:0] result, input int bp);
        int g;
        int e;
        logic exp_err;
        logic [DW-1:0] exp_data;
        g = model_grant(mask);
        exp_err  = !(delay >= 1 && delay <= TO);
        exp_data = exp_err ? '0 : result;
        e        = exp_err ? TO + 1 : delay + 1;
        for (int i = 0; i < NR; i++) begin
            bus.req_instr[i*DW +: DW] = (i == g) ? instr_g : DW'($urandom());
        end
        bus.req_valid = mask;
        bus.rsp_ready = (bp == 0);
        bus.core_done = 1'b0;

        @(negedge clk);
        check_eq("req_ready_grant", bus.req_ready, 64'(1) << g);
        check_eq("idle_busy", bus.busy, 0);
        check_eq("idle_rsp_valid", bus.rsp_valid, 0);
        model_last = g;

        @(posedge clk); #1;
        bus.req_instr[g*DW +: DW] = DW'($urandom());
        @(negedge clk);
        check_eq("core_start", bus.core_start, 1);
        check_eq("core_instr", bus.core_instr, instr_g);
        check_eq("issue_busy", bus.busy, 1);
        check_eq("issue_req_ready", bus.req_ready, 0);

        for (int j = 1; j < e; j++) begin
            @(posedge clk); #1;
            bus.core_done   = (j == delay);
            bus.core_result = (j == delay) ? result : DW'($urandom());
            @(negedge clk);
            check_eq("wait_quiet", {bus.core_start, bus.rsp_valid, bus.req_ready}, 0);
            check_eq("wait_instr_hold", bus.core_instr, instr_g);
        end

        @(posedge clk); #1;
        bus.core_done = 1'b0;
        for (int b = 0; b <= bp; b++) begin
            if (b > 0) begin
                @(posedge clk); #1;
            end
            bus.rsp_ready   = (b == bp);
            bus.core_done   = (b < bp) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.core_result = DW'($urandom());
            @(negedge clk);
            check_eq("rsp_valid", bus.rsp_valid, 1);
            check_eq("rsp_id", bus.rsp_id, g);
            check_eq("rsp_data", bus.rsp_data, exp_data);
            check_eq("rsp_err", bus.rsp_err, exp_err);
            check_eq("wb_addr", bus.wb_addr, model_wb % (1 << AW));
            check_eq("wb_addr_narrow", bus2.wb_addr, model_wb % (1 << AW2));
            check_eq("resp_quiet", {bus.core_start, bus.req_ready}, 0);
        end
        $display("txn %0d grant=%0d delay=%0d bp=%0d err=%0d data=%08h wb=%0d",
                 txn_no, g, delay, bp, exp_err, exp_data, model_wb);
        model_wb++;
        txn_no++;
        @(posedge clk); #1;
        bus.core_done = 1'b0;
        bus.rsp_ready = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        bus.req_valid = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("idle_quiet", {bus.core_start, bus.busy, bus.rsp_valid, bus.req_ready}, 0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int delay;
        int r;
        rst_n           = 1'b1;
        bus.req_valid   = '0;
        bus.req_instr   = '0;
        bus.core_done   = 1'b0;
        bus.core_result = '0;
        bus.rsp_ready   = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_eq("reset_outputs", {bus.req_ready, bus.core_start, bus.rsp_valid, bus.rsp_err,
                                   bus.rsp_id, bus.busy}, 0);
        check_eq("reset_data", {bus.core_instr, bus.rsp_data}, 0);
        check_eq("reset_wb_addr", bus.wb_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(20);

        // single request from requester 2, core completes 5 cycles after start
        run_txn(4'b0100, 32'h0022_1000, 5, 32'h3, 0);

        // all requesters continuously valid
        for (int i = 0; i < 8; i++) run_txn(4'b1111, DW'($urandom()), 5, DW'($urandom()), 0);

        // response backpressure
        run_txn(4'b1111, DW'($urandom()), 5, DW'($urandom()), 10);

        // timeout, done exactly at the limit, done one past the limit
        run_txn(4'b1010, DW'($urandom()), 0, DW'($urandom()), 0);
        run_txn(4'b1010, DW'($urandom()), TO, DW'($urandom()), 0);
        run_txn(4'b0011, DW'($urandom()), TO + 1, DW'($urandom()), 2);

        // reset while waiting on the core
        model_grant_reset : begin
            bus.req_valid = 4'b1111;
            @(negedge clk);
            check_eq("pre_reset_accept", |bus.req_ready, 1);
            repeat (4) @(posedge clk);
            #1;
            bus.req_valid = '0;
            rst_n = 1'b0;
            #1;
            check_eq("mid_reset_busy", bus.busy, 0);
            check_eq("mid_reset_rsp_valid", bus.rsp_valid, 0);
            check_eq("mid_reset_wb_addr", bus.wb_addr, 0);
            model_last = NR - 1;
            model_wb   = 0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            idle_cycles(3);
        end
        run_txn(4'b1111, DW'($urandom()), 5, DW'($urandom()), 0);

        // randomized mix
        for (int i = 0; i < 30; i++) begin
            r     = $urandom_range(0, 9);
            delay = (r == 0) ? 0 : $urandom_range(1, TO + 2);
            run_txn(NR'($urandom_range(1, (1 << NR) - 1)), DW'($urandom()), delay,
                    DW'($urandom()), $urandom_range(0, 3));
        end
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
